// File: rtl/cube_frame_scheduler.sv
// cube_frame_scheduler
// Chooses between UART frames and locally generated frames for the LED cube,
// keeps the UART receiver byte-aligned by pulsing its reset after an idle gap
// on the serial line, and double-buffers the chosen frame so the scanner only
// sees a new frame at the end of a full refresh.
module cube_frame_scheduler #(
    parameter int GAP_CYCLES     = 100000,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rx,
    input  logic         force_local,
    input  logic [511:0] uart_frame_flat,
    input  logic         uart_frame_valid,
    output logic         uart_rst,
    output logic         uart_en,
    input  logic [511:0] loc_frame_flat,
    input  logic         loc_frame_valid,
    output logic         loc_frame_ready,
    input  logic         scan_frame_done,
    output logic [511:0] disp_frame_flat,
    output logic         src_uart,
    output logic         swap_pulse,
    output logic         drop_pulse
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [0:0] {
        SRC_LOCAL = 1'b0,
        SRC_UART  = 1'b1
    } src_state_t;

    // rx synchronizer and resync logic
    logic             rx_meta_r;
    logic             rx_sync_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [GAP_W-1:0] gap_cnt_s;
    logic             armed_r;
    logic             armed_s;
    logic             resync_s;
    logic             uart_rst_r;

    // source selection
    src_state_t       state_r;
    src_state_t       state_s;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_s;
    logic             uart_en_r;

    // frame buffering
    logic             uart_acc_s;
    logic             loc_ready_s;
    logic             loc_acc_s;
    logic             cap_s;
    logic [511:0]     cap_data_s;
    logic             swap_s;
    logic             drop_s;
    logic             pending_r;
    logic             pending_s;
    logic [511:0]     back_r;
    logic [511:0]     front_r;
    logic             swap_pulse_r;
    logic             drop_pulse_r;

    // Two-flop synchronizer on the raw serial line; idles high so resets to 1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Idle-gap counter and arm flag: a resync fires once per idle period, only after rx has been low
    always_comb begin
        gap_cnt_s = gap_cnt_r;
        armed_s   = armed_r;
        resync_s  = 1'b0;
        if (!rx_sync_r) begin
            gap_cnt_s = '0;
            armed_s   = 1'b1;
        end else begin
            if (gap_cnt_r != GAP_MAX) begin
                gap_cnt_s = gap_cnt_r + GAP_W'(1);
            end else begin
                gap_cnt_s = gap_cnt_r;
            end
            if ((gap_cnt_r == GAP_MAX) && armed_r) begin
                resync_s = 1'b1;
                armed_s  = 1'b0;
            end else begin
                resync_s = 1'b0;
                armed_s  = armed_r;
            end
        end
    end

    // Resync state registers; receiver reset is held high through our own reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt_r  <= '0;
            armed_r    <= 1'b0;
            uart_rst_r <= 1'b1;
        end else begin
            gap_cnt_r  <= gap_cnt_s;
            armed_r    <= armed_s;
            uart_rst_r <= resync_s;
        end
    end

    assign uart_acc_s = uart_frame_valid & ~force_local;

    // Source FSM next state and UART silence timeout
    always_comb begin
        state_s   = state_r;
        tmo_cnt_s = tmo_cnt_r;
        case (state_r)
            SRC_LOCAL: begin
                tmo_cnt_s = '0;
                if (uart_acc_s) begin
                    state_s = SRC_UART;
                end else begin
                    state_s = SRC_LOCAL;
                end
            end
            SRC_UART: begin
                if (force_local) begin
                    state_s   = SRC_LOCAL;
                    tmo_cnt_s = '0;
                end else if (uart_acc_s) begin
                    // a fresh frame keeps the UART source alive even on the timeout cycle
                    state_s   = SRC_UART;
                    tmo_cnt_s = '0;
                end else if (tmo_cnt_r == TMO_MAX) begin
                    state_s   = SRC_LOCAL;
                    tmo_cnt_s = '0;
                end else begin
                    state_s   = SRC_UART;
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                end
            end
            default: begin
                state_s   = SRC_LOCAL;
                tmo_cnt_s = '0;
            end
        endcase
    end

    // Source FSM state, timeout counter and receiver enable registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= SRC_LOCAL;
            tmo_cnt_r <= '0;
            uart_en_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            tmo_cnt_r <= tmo_cnt_s;
            uart_en_r <= ~force_local;
        end
    end

    // Capture selection, swap trigger and pending/drop bookkeeping
    always_comb begin
        loc_ready_s = (state_r == SRC_LOCAL) & ~pending_r & ~uart_frame_valid;
        loc_acc_s   = loc_frame_valid & loc_ready_s;
        cap_s       = uart_acc_s | loc_acc_s;
        swap_s      = scan_frame_done & pending_r;
        // a capture coinciding with a swap is not a drop: the old back frame moves to front
        drop_s      = uart_acc_s & pending_r & ~swap_s;
        if (uart_acc_s) begin
            cap_data_s = uart_frame_flat;
        end else begin
            cap_data_s = loc_frame_flat;
        end
        if (cap_s) begin
            pending_s = 1'b1;
        end else if (swap_s) begin
            pending_s = 1'b0;
        end else begin
            pending_s = pending_r;
        end
    end

    // Back/front frame buffers and single-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            back_r       <= '0;
            front_r      <= '0;
            pending_r    <= 1'b0;
            swap_pulse_r <= 1'b0;
            drop_pulse_r <= 1'b0;
        end else begin
            if (cap_s) begin
                back_r <= cap_data_s;
            end
            if (swap_s) begin
                front_r <= back_r;
            end
            pending_r    <= pending_s;
            swap_pulse_r <= swap_s;
            drop_pulse_r <= drop_s;
        end
    end

    assign uart_rst        = uart_rst_r;
    assign uart_en         = uart_en_r;
    assign loc_frame_ready = loc_ready_s;
    assign disp_frame_flat = front_r;
    assign src_uart        = (state_r == SRC_UART);
    assign swap_pulse      = swap_pulse_r;
    assign drop_pulse      = drop_pulse_r;

endmodule

// File: tb/tb_cube_frame_scheduler.sv
// Self-checking bench for cube_frame_scheduler (GAP_CYCLES=16, TIMEOUT_CYCLES=64).
// Displayed frames are predicted by a small buffer model and queued when the
// swap-triggering stimulus is driven; a monitor pops them on each swap_pulse.
module tb_cube_frame_scheduler;

    logic         clk;
    logic         rst;
    logic         rx;
    logic         force_local;
    logic [511:0] uart_frame_flat;
    logic         uart_frame_valid;
    logic         uart_rst;
    logic         uart_en;
    logic [511:0] loc_frame_flat;
    logic         loc_frame_valid;
    logic         loc_frame_ready;
    logic         scan_frame_done;
    logic [511:0] disp_frame_flat;
    logic         src_uart;
    logic         swap_pulse;
    logic         drop_pulse;

    int checks = 0;
    int errors = 0;

    // buffer model
    bit           m_pending;
    bit           m_src_uart;
    logic [511:0] m_back;
    logic [511:0] exp_q[$];
    logic [511:0] mon_exp;

    cube_frame_scheduler #(
        .GAP_CYCLES(16),
        .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .force_local(force_local),
        .uart_frame_flat(uart_frame_flat),
        .uart_frame_valid(uart_frame_valid),
        .uart_rst(uart_rst),
        .uart_en(uart_en),
        .loc_frame_flat(loc_frame_flat),
        .loc_frame_valid(loc_frame_valid),
        .loc_frame_ready(loc_frame_ready),
        .scan_frame_done(scan_frame_done),
        .disp_frame_flat(disp_frame_flat),
        .src_uart(src_uart),
        .swap_pulse(swap_pulse),
        .drop_pulse(drop_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] fill(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle of frame inputs, updates the model and queues any expected display.
    task automatic drive_cycle(input bit uv, input logic [511:0] uf, input bit lv,
                               input logic [511:0] lf, input bit scan, output bit exp_drop);
        bit uacc;
        bit lacc;
        bit swp;
        uart_frame_valid = uv;
        uart_frame_flat  = uf;
        loc_frame_valid  = lv;
        loc_frame_flat   = lf;
        scan_frame_done  = scan;
        uacc = uv && !force_local;
        lacc = lv && !m_src_uart && !m_pending && !uv;
        swp  = scan && m_pending;
        if (swp) exp_q.push_back(m_back);
        exp_drop = uacc && m_pending && !swp;
        if (uacc) begin
            m_back     = uf;
            m_src_uart = 1'b1;
        end else if (lacc) begin
            m_back = lf;
        end
        if (uacc || lacc) m_pending = 1'b1;
        else if (swp) m_pending = 1'b0;
        tick();
        uart_frame_valid = 1'b0;
        loc_frame_valid  = 1'b0;
        scan_frame_done  = 1'b0;
    endtask

    // Scoreboard monitor: every swap_pulse must match the next expected frame
    initial begin
        forever begin
            @(negedge clk);
            if (swap_pulse === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL swap_unexpected: swap_pulse=1 disp=%h, required no swap", disp_frame_flat[63:0]);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (disp_frame_flat !== mon_exp) begin
                        errors++;
                        $display("FAIL swap_disp: disp=%h required %h", disp_frame_flat, mon_exp);
                    end
                end
            end
        end
    end

    task automatic test_reset();
        int pulses;
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (uart_rst !== 1'b1 || src_uart !== 1'b0 || uart_en !== 1'b0 || swap_pulse !== 1'b0 ||
            drop_pulse !== 1'b0 || disp_frame_flat !== 512'd0) begin
            errors++;
            $display("FAIL reset_values: uart_rst=%b src_uart=%b uart_en=%b swap=%b drop=%b disp0=%h required 1 0 0 0 0 0",
                     uart_rst, src_uart, uart_en, swap_pulse, drop_pulse, disp_frame_flat[31:0]);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (uart_rst !== 1'b0 || uart_en !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: uart_rst=%b uart_en=%b required 0 1", uart_rst, uart_en);
        end
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (uart_rst === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_no_resync: pulses=%0d required 0", pulses);
        end
        checks++;
        if (src_uart !== 1'b0 || disp_frame_flat !== 512'd0 || loc_frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: src_uart=%b disp0=%h ready=%b required 0 0 1",
                     src_uart, disp_frame_flat[31:0], loc_frame_ready);
        end
    endtask

    task automatic test_local();
        bit d;
        loc_frame_valid = 1'b1;
        loc_frame_flat  = fill(8'hA5);
        #1;
        checks++;
        if (loc_frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL local_ready: ready=%b required 1", loc_frame_ready);
        end
        drive_cycle(1'b0, 512'd0, 1'b1, fill(8'hA5), 1'b0, d);
        checks++;
        if (loc_frame_ready !== 1'b0) begin
            errors++;
            $display("FAIL local_ready_pending: ready=%b required 0", loc_frame_ready);
        end
        drive_cycle(1'b0, 512'd0, 1'b0, 512'd0, 1'b1, d);
        checks++;
        if (swap_pulse !== 1'b1 || disp_frame_flat !== fill(8'hA5) || loc_frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL local_swap: swap=%b disp0=%h ready=%b required 1 a5a5a5a5 1",
                     swap_pulse, disp_frame_flat[31:0], loc_frame_ready);
        end
        tick();
        checks++;
        if (swap_pulse !== 1'b0) begin
            errors++;
            $display("FAIL local_swap_width: swap=%b required 0", swap_pulse);
        end
    endtask

    task automatic test_resync();
        int pulses;
        int at;
        rx = 1'b0;
        repeat (5) tick();
        rx = 1'b1;
        pulses = 0;
        at = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (uart_rst === 1'b1) begin
                pulses++;
                if (at < 0) at = k;
            end
        end
        checks++;
        if (pulses !== 1 || at !== 18) begin
            errors++;
            $display("FAIL resync_pulse: pulses=%0d at=%0d required 1 at 18", pulses, at);
        end
        pulses = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (uart_rst === 1'b1) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL resync_once: pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_uart_drop();
        bit d;
        drive_cycle(1'b1, fill(8'h3C), 1'b0, 512'd0, 1'b0, d);
        checks++;
        if (src_uart !== 1'b1 || loc_frame_ready !== 1'b0 || drop_pulse !== d) begin
            errors++;
            $display("FAIL uart_first: src_uart=%b ready=%b drop=%b required 1 0 %b",
                     src_uart, loc_frame_ready, drop_pulse, d);
        end
        drive_cycle(1'b1, fill(8'h11), 1'b0, 512'd0, 1'b0, d);
        checks++;
        if (drop_pulse !== d || d !== 1'b1) begin
            errors++;
            $display("FAIL uart_drop: drop=%b required %b", drop_pulse, d);
        end
        drive_cycle(1'b0, 512'd0, 1'b0, 512'd0, 1'b0, d);
        checks++;
        if (drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL uart_drop_width: drop=%b required 0", drop_pulse);
        end
        drive_cycle(1'b0, 512'd0, 1'b0, 512'd0, 1'b1, d);
        checks++;
        if (disp_frame_flat !== fill(8'h11)) begin
            errors++;
            $display("FAIL uart_disp: disp0=%h required 11111111", disp_frame_flat[31:0]);
        end
    endtask

    task automatic test_simultaneous();
        bit d;
        drive_cycle(1'b1, fill(8'h22), 1'b0, 512'd0, 1'b0, d);
        drive_cycle(1'b1, fill(8'h44), 1'b0, 512'd0, 1'b1, d);
        checks++;
        if (drop_pulse !== 1'b0 || swap_pulse !== 1'b1 || disp_frame_flat !== fill(8'h22)) begin
            errors++;
            $display("FAIL simul_swap: drop=%b swap=%b disp0=%h required 0 1 22222222",
                     drop_pulse, swap_pulse, disp_frame_flat[31:0]);
        end
        drive_cycle(1'b0, 512'd0, 1'b0, 512'd0, 1'b1, d);
        checks++;
        if (swap_pulse !== 1'b1 || disp_frame_flat !== fill(8'h44)) begin
            errors++;
            $display("FAIL simul_pending: swap=%b disp0=%h required 1 44444444",
                     swap_pulse, disp_frame_flat[31:0]);
        end
    endtask

    task automatic test_timeout_force();
        bit d;
        int fall;
        drive_cycle(1'b1, fill(8'h5A), 1'b0, 512'd0, 1'b0, d);
        m_src_uart = 1'b0;
        fall = -1;
        for (int k = 1; k <= 70; k++) begin
            tick();
            if (fall < 0 && src_uart === 1'b0) fall = k;
        end
        checks++;
        if (fall !== 64) begin
            errors++;
            $display("FAIL timeout_fall: fell at %0d required 64", fall);
        end
        drive_cycle(1'b0, 512'd0, 1'b0, 512'd0, 1'b1, d);
        drive_cycle(1'b1, fill(8'h77), 1'b0, 512'd0, 1'b0, d);
        force_local = 1'b1;
        m_src_uart  = 1'b0;
        drive_cycle(1'b1, fill(8'h99), 1'b0, 512'd0, 1'b0, d);
        checks++;
        if (src_uart !== 1'b0 || uart_en !== 1'b0 || drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL force_local: src_uart=%b uart_en=%b drop=%b required 0 0 0",
                     src_uart, uart_en, drop_pulse);
        end
        drive_cycle(1'b0, 512'd0, 1'b0, 512'd0, 1'b1, d);
        force_local = 1'b0;
        tick();
        checks++;
        if (loc_frame_ready !== 1'b1 || uart_en !== 1'b1) begin
            errors++;
            $display("FAIL force_release: ready=%b uart_en=%b required 1 1", loc_frame_ready, uart_en);
        end
    endtask

    initial begin
        rst              = 1'b1;
        rx               = 1'b1;
        force_local      = 1'b0;
        uart_frame_flat  = 512'd0;
        uart_frame_valid = 1'b0;
        loc_frame_flat   = 512'd0;
        loc_frame_valid  = 1'b0;
        scan_frame_done  = 1'b0;
        m_pending        = 1'b0;
        m_src_uart       = 1'b0;
        m_back           = 512'd0;
        test_reset();
        test_local();
        test_resync();
        test_uart_drop();
        test_simultaneous();
        test_timeout_force();
        repeat (3) tick();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL swaps_missing: %0d expected frames never displayed, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
